// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampling UART receiver with a configurable frame format.
// The word width, oversampling ratio, parity mode and stop-bit count are all
// configurable. The receiver rejects false starts. It flags parity, framing,
// break and overrun conditions. Received words are presented through a
// valid/ready holding register.
//
// Ports
//   clk            system clock
//   i_rst_n        asynchronous active-low reset
//   i_tick         one-cycle strobe at OVERSAMPLE x baud
//   i_rx           serial line (asynchronous, idle high)
//   i_parity_mode  00 none, 01 even, 10 odd, 11 none (latched at start edge)
//   i_stop2        1 = two stop bits checked (latched at start edge)
//   i_ready        consumer accepts o_data while o_valid=1
//   o_data         received word (holding register)
//   o_valid        holding register full
//   o_parity_err   parity mismatch for the word in o_data
//   o_frame_err    a stop bit sampled 0 for the word in o_data
//   o_break        data, parity (if enabled) and first stop bit all 0
//   o_overrun      sticky: a frame was dropped while the holding register was full
//   o_busy         receiver FSM not in IDLE
//
// State   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for the synchronised line to go low
// START   | counting to mid start bit; a high sample there is a false start
// DATA    | sampling NB_DATA data bits at mid bit, LSB first
// PARITY  | sampling the parity bit (only when parity is enabled)
// STOP    | sampling one or two stop bits; back to IDLE at mid last stop bit
module uart_rx_cfg #(
  parameter int NB_DATA    = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_tick,
  input  logic               i_rx,
  input  logic [1:0]         i_parity_mode,
  input  logic               i_stop2,
  input  logic               i_ready,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_valid,
  output logic               o_parity_err,
  output logic               o_frame_err,
  output logic               o_break,
  output logic               o_overrun,
  output logic               o_busy
);

  localparam int NB_TICK = $clog2(OVERSAMPLE);
  localparam int NB_BCNT = $clog2(NB_DATA + 1);
  localparam logic [NB_TICK-1:0] TICK_MID = NB_TICK'(OVERSAMPLE / 2 - 1);
  localparam logic [NB_TICK-1:0] TICK_END = NB_TICK'(OVERSAMPLE - 1);
  localparam logic [NB_BCNT-1:0] BIT_LAST = NB_BCNT'(NB_DATA - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t               state_q, state_d;
  logic                 rx_meta_q, rx_meta_d;
  logic                 rx_s_q, rx_s_d;
  logic [NB_TICK-1:0]   tick_cnt_q, tick_cnt_d;
  logic [NB_BCNT-1:0]   bit_cnt_q, bit_cnt_d;
  logic [NB_DATA-1:0]   shift_q, shift_d;
  logic [1:0]           par_mode_q, par_mode_d;
  logic                 stop2_q, stop2_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 perr_acc_q, perr_acc_d;
  logic                 ferr_acc_q, ferr_acc_d;
  logic                 zero_q, zero_d;
  logic [NB_DATA-1:0]   data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 brk_q, brk_d;
  logic                 ovr_q, ovr_d;

  logic                 tick_end;
  logic                 par_en;
  logic                 complete;

  always_comb begin
    state_d    = state_q;
    rx_meta_d  = i_rx;
    rx_s_d     = rx_meta_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_mode_d = par_mode_q;
    stop2_d    = stop2_q;
    stop_cnt_d = stop_cnt_q;
    perr_acc_d = perr_acc_q;
    ferr_acc_d = ferr_acc_q;
    zero_d     = zero_q;
    data_d     = data_q;
    valid_d    = valid_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    brk_d      = brk_q;
    ovr_d      = ovr_q;
    complete   = 1'b0;

    tick_end = i_tick && (tick_cnt_q == TICK_END);
    par_en   = (par_mode_q == 2'b01) || (par_mode_q == 2'b10);

    // Shared bit-period timer for the sampling states.
    if ((state_q == ST_DATA) || (state_q == ST_PARITY) || (state_q == ST_STOP)) begin
      if (i_tick) begin
        tick_cnt_d = tick_end ? '0 : tick_cnt_q + 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (!rx_s_q) begin
          par_mode_d = i_parity_mode;
          stop2_d    = i_stop2;
          tick_cnt_d = '0;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        if (i_tick) begin
          if (tick_cnt_q == TICK_MID) begin
            if (rx_s_q) begin
              state_d = ST_IDLE;
            end else begin
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
              stop_cnt_d = 1'b0;
              perr_acc_d = 1'b0;
              ferr_acc_d = 1'b0;
              zero_d     = 1'b1;
              state_d    = ST_DATA;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (tick_end) begin
          shift_d   = {rx_s_q, shift_q[NB_DATA-1:1]};
          zero_d    = zero_q & ~rx_s_q;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_LAST) begin
            state_d = par_en ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (tick_end) begin
          perr_acc_d = ((^shift_q) ^ rx_s_q) != (par_mode_q == 2'b10);
          zero_d     = zero_q & ~rx_s_q;
          state_d    = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick_end) begin
          if (!rx_s_q) begin
            ferr_acc_d = 1'b1;
          end
          // Only the first stop bit takes part in break detection.
          if (!stop_cnt_q) begin
            zero_d = zero_q & ~rx_s_q;
          end
          stop_cnt_d = 1'b1;
          if (stop_cnt_q || !stop2_q) begin
            complete = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (valid_q && i_ready) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
      perr_d  = 1'b0;
      ferr_d  = 1'b0;
      brk_d   = 1'b0;
    end

    // A slot being read out this cycle counts as free.
    if (complete) begin
      if (!valid_q || i_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
        perr_d  = perr_acc_q;
        ferr_d  = ferr_acc_q | ~rx_s_q;
        brk_d   = zero_d;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_mode_q <= 2'b00;
      stop2_q    <= 1'b0;
      stop_cnt_q <= 1'b0;
      perr_acc_q <= 1'b0;
      ferr_acc_q <= 1'b0;
      zero_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      brk_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_meta_q  <= rx_meta_d;
      rx_s_q     <= rx_s_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_mode_q <= par_mode_d;
      stop2_q    <= stop2_d;
      stop_cnt_q <= stop_cnt_d;
      perr_acc_q <= perr_acc_d;
      ferr_acc_q <= ferr_acc_d;
      zero_q     <= zero_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      brk_q      <= brk_d;
      ovr_q      <= ovr_d;
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_parity_err = perr_q;
  assign o_frame_err  = ferr_q;
  assign o_break      = brk_q;
  assign o_overrun    = ovr_q;
  assign o_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Testbench for uart_rx_cfg (NB_DATA=8, OVERSAMPLE=16). Frames are built bit by
// bit on the line. The expected word and flags are computed from the frame
// contents and queued. A monitor checks each word when the consumer accepts it.
module tb_uart_rx_cfg;

  localparam int OS = 16;
  localparam int NB = 8;

  logic          clk;
  logic          i_rst_n;
  logic          i_tick;
  logic          i_rx;
  logic [1:0]    i_parity_mode;
  logic          i_stop2;
  logic          i_ready;
  logic [NB-1:0] o_data;
  logic          o_valid;
  logic          o_parity_err;
  logic          o_frame_err;
  logic          o_break;
  logic          o_overrun;
  logic          o_busy;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
    logic       ovr;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  uart_rx_cfg #(.NB_DATA(NB), .OVERSAMPLE(OS)) dut (
    .clk           (clk),
    .i_rst_n       (i_rst_n),
    .i_tick        (i_tick),
    .i_rx          (i_rx),
    .i_parity_mode (i_parity_mode),
    .i_stop2       (i_stop2),
    .i_ready       (i_ready),
    .o_data        (o_data),
    .o_valid       (o_valid),
    .o_parity_err  (o_parity_err),
    .o_frame_err   (o_frame_err),
    .o_break       (o_break),
    .o_overrun     (o_overrun),
    .o_busy        (o_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Baud tick: one clk high every four clk.
  initial begin
    i_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      i_tick = 1'b1;
      @(negedge clk);
      i_tick = 1'b0;
    end
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d", sb_q.size());
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: each accepted word is compared with the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (i_rst_n && o_valid && i_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_word: got data 0x%0h, expected no word", o_data);
      end else begin
        e = sb_q.pop_front();
        check("word_data", 32'(o_data), 32'(e.data));
        check("word_parity_err", 32'(o_parity_err), 32'(e.perr));
        check("word_frame_err", 32'(o_frame_err), 32'(e.ferr));
        check("word_break", 32'(o_break), 32'(e.brk));
        check("word_overrun", 32'(o_overrun), 32'(e.ovr));
      end
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge clk); while (i_tick !== 1'b1);
    end
    #1;
  endtask

  task automatic send_bit(input logic b, input int n);
    i_rx = b;
    wait_ticks(n);
  endtask

  // bad_stop zeroes the last stop bit. A zero last stop bit is released
  // shortly after its mid point so the line does not look like a new start.
  task automatic send_frame(input logic [7:0] d, input logic [1:0] pm, input logic s2,
                            input logic flip_par, input logic bad_stop, input bit drop);
    logic pen, odd, pbit, st1, st2, last;
    exp_t e;
    pen  = (pm == 2'b01) || (pm == 2'b10);
    odd  = (pm == 2'b10);
    pbit = (($countones(d) % 2) == 1) ^ odd ^ flip_par;
    st1  = s2 ? 1'b1 : ~bad_stop;
    st2  = ~bad_stop;
    last = s2 ? st2 : st1;
    e.data = d;
    e.perr = pen && flip_par;
    e.ferr = bad_stop;
    e.brk  = (d == 8'h00) && (!pen || !pbit) && !st1;
    e.ovr  = 1'b0;
    if (drop) begin
      if (sb_q.size() > 0) sb_q[sb_q.size()-1].ovr = 1'b1;
    end else begin
      sb_q.push_back(e);
    end
    i_parity_mode = pm;
    i_stop2       = s2;
    send_bit(1'b0, OS);
    // Configuration changes after the start edge must be ignored.
    i_parity_mode = 2'($urandom_range(0, 3));
    i_stop2       = 1'($urandom_range(0, 1));
    for (int i = 0; i < NB; i++) send_bit(d[i], OS);
    if (pen) send_bit(pbit, OS);
    if (s2) send_bit(st1, OS);
    if (last) begin
      send_bit(1'b1, OS);
    end else begin
      send_bit(1'b0, OS / 2 + 2);
      send_bit(1'b1, OS);
    end
  endtask

  initial begin
    logic [7:0] rd;
    logic [1:0] rpm;
    logic       rs2, rflip, rbad;
    int         gap;

    i_rst_n       = 1'b0;
    i_rx          = 1'b1;
    i_ready       = 1'b1;
    i_parity_mode = 2'b00;
    i_stop2       = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("reset_valid", 32'(o_valid), 32'd0);
    check("reset_data", 32'(o_data), 32'd0);
    check("reset_busy", 32'(o_busy), 32'd0);
    check("reset_flags", 32'({o_parity_err, o_frame_err, o_break, o_overrun}), 32'd0);
    i_rst_n = 1'b1;
    wait_ticks(4);

    // 8N1 basic word: o_valid is a single-cycle pulse when ready is high.
    send_frame(8'hA5, 2'b00, 1'b0, 1'b0, 1'b0, 0);
    check("a5_valid_pulse_gone", 32'(o_valid), 32'd0);
    check("a5_idle", 32'(o_busy), 32'd0);

    // Even parity: wrong parity bit, then correct.
    send_frame(8'h3C, 2'b01, 1'b0, 1'b1, 1'b0, 0);
    send_frame(8'h3C, 2'b01, 1'b0, 1'b0, 1'b0, 0);

    // False start: line low for 4 ticks only.
    i_rx = 1'b0;
    wait_ticks(4);
    i_rx = 1'b1;
    wait_ticks(OS);
    check("false_start_busy", 32'(o_busy), 32'd0);
    check("false_start_valid", 32'(o_valid), 32'd0);
    send_frame(8'h55, 2'b00, 1'b0, 1'b0, 1'b0, 0);

    // Overrun: consumer stalled across two frames.
    i_ready = 1'b0;
    send_frame(8'h11, 2'b00, 1'b0, 1'b0, 1'b0, 0);
    send_frame(8'h22, 2'b00, 1'b0, 1'b0, 1'b0, 1);
    check("ovr_data_held", 32'(o_data), 32'h11);
    check("ovr_valid", 32'(o_valid), 32'd1);
    check("ovr_flag", 32'(o_overrun), 32'd1);
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    check("ovr_valid_cleared", 32'(o_valid), 32'd0);
    check("ovr_flag_cleared", 32'(o_overrun), 32'd0);

    // Framing: second stop bit low, then a break (line low for a whole frame).
    send_frame(8'h5A, 2'b00, 1'b1, 1'b0, 1'b1, 0);
    send_frame(8'h00, 2'b00, 1'b0, 1'b0, 1'b1, 0);
    send_frame(8'h00, 2'b10, 1'b0, 1'b0, 1'b0, 0);

    // Reset in the middle of the data bits of 0xF0.
    send_bit(1'b0, OS);
    send_bit(1'b0, OS);
    send_bit(1'b0, OS);
    send_bit(1'b0, OS / 2);
    check("mid_frame_busy", 32'(o_busy), 32'd1);
    i_rst_n = 1'b0;
    #2;
    check("abort_busy", 32'(o_busy), 32'd0);
    check("abort_valid", 32'(o_valid), 32'd0);
    i_rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    i_rst_n = 1'b1;
    wait_ticks(OS);
    send_frame(8'h0F, 2'b00, 1'b0, 1'b0, 1'b0, 0);

    // Random frames: random format, corrupted parity/stop and back-to-back gaps.
    for (int n = 0; n < 20; n++) begin
      rd    = 8'($urandom);
      rpm   = 2'($urandom_range(0, 3));
      rs2   = 1'($urandom_range(0, 1));
      rflip = ($urandom_range(0, 3) == 0);
      rbad  = ($urandom_range(0, 4) == 0);
      send_frame(rd, rpm, rs2, rflip, rbad, 0);
      gap = int'($urandom_range(0, 2)) * (OS / 2);
      if (gap > 0) wait_ticks(gap);
    end

    for (int k = 0; k < 2000 && sb_q.size() != 0; k++) @(posedge clk);
    #1;
    check("all_words_delivered", 32'(sb_q.size()), 32'd0);
    check("end_idle", 32'(o_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
